// File: rtl/regfile_wr_arb_if.sv
// Write-port bundle between the two writeback requesters, the arbiter and the
// register-file write port.
interface regfile_wr_arb_if;
  logic        A_req;
  logic [4:0]  A_Addr;
  logic [31:0] A_Data;
  logic        A_ack;
  logic        B_req;
  logic [4:0]  B_Addr;
  logic [31:0] B_Data;
  logic        B_ack;
  logic        D_En;
  logic [4:0]  D_Addr;
  logic [31:0] D_in;
  logic        B_starve;

  modport master (
    output A_req, A_Addr, A_Data, B_req, B_Addr, B_Data,
    input  A_ack, B_ack, D_En, D_Addr, D_in, B_starve
  );

  modport slave (
    input  A_req, A_Addr, A_Data, B_req, B_Addr, B_Data,
    output A_ack, B_ack, D_En, D_Addr, D_in, B_starve
  );
endinterface

// File: rtl/regfile_wr_arb.sv
// Two-requester register-file write arbiter: A has priority, B is forced
// through after three consecutive denied cycles. Write port is registered.
//
// state   | meaning
// PRIO_A  | A wins when both request; denied B cycles are counted
// FORCE_B | B starved for three cycles, B granted unconditionally
module regfile_wr_arb (
  input  logic             clk,
  input  logic             reset,
  regfile_wr_arb_if.slave  bus
);

  typedef enum logic {PRIO_A = 1'b0, FORCE_B = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_wait_cnt;
  logic [1:0]  w_wait_cnt_nxt;
  logic        w_grant_a;
  logic        w_grant_b;
  logic        w_grant_any;
  logic [4:0]  w_wr_addr;
  logic [31:0] w_wr_data;
  logic        r_d_en;
  logic [4:0]  r_d_addr;
  logic [31:0] r_d_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= PRIO_A;
      r_wait_cnt <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  always_comb begin
    w_grant_a      = 1'b0;
    w_grant_b      = 1'b0;
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    if (r_state == FORCE_B) begin
      w_grant_b      = bus.B_req;
      w_state_nxt    = PRIO_A;
      w_wait_cnt_nxt = 2'd0;
    end else begin
      if (bus.A_req) begin
        w_grant_a = 1'b1;
      end else if (bus.B_req) begin
        w_grant_b = 1'b1;
      end
      // Only consecutive denied cycles count; a dropped request restarts it.
      if (w_grant_b || !bus.B_req) begin
        w_wait_cnt_nxt = 2'd0;
      end else if (r_wait_cnt != 2'd3) begin
        w_wait_cnt_nxt = r_wait_cnt + 2'd1;
      end
      if (w_wait_cnt_nxt == 2'd3) begin
        w_state_nxt = FORCE_B;
      end
    end
  end

  assign w_grant_any = w_grant_a | w_grant_b;
  assign w_wr_addr   = w_grant_b ? bus.B_Addr : bus.A_Addr;
  assign w_wr_data   = w_grant_b ? bus.B_Data : bus.A_Data;

  // Writes to $zero are acked but never reach the register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d_en   <= 1'b0;
      r_d_addr <= 5'd0;
      r_d_in   <= 32'd0;
    end else if (w_grant_any) begin
      r_d_en   <= (w_wr_addr != 5'd0);
      r_d_addr <= w_wr_addr;
      r_d_in   <= w_wr_data;
    end else begin
      r_d_en   <= 1'b0;
    end
  end

  assign bus.A_ack    = w_grant_a & ~reset;
  assign bus.B_ack    = w_grant_b & ~reset;
  assign bus.B_starve = (r_state == FORCE_B) & ~reset;
  assign bus.D_En     = r_d_en;
  assign bus.D_Addr   = r_d_addr;
  assign bus.D_in     = r_d_in;

endmodule

// File: doc/regfile_wr_arb.md
REGFILE_WR_ARB -- requirements
Module: regfile_wr_arb

Interface
REQ-001 SHALL provide port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL provide port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL provide port: A_req  input  1  requester A (ALU writeback) write request.
REQ-004 SHALL provide port: A_Addr  input  5  requester A destination register.
REQ-005 SHALL provide port: A_Data  input  32  requester A write data.
REQ-006 SHALL provide port: A_ack  output  1  one-cycle pulse, A request accepted.
REQ-007 SHALL provide port: B_req  input  1  requester B (load / HI-LO move) write request.
REQ-008 SHALL provide port: B_Addr  input  5  requester B destination register.
REQ-009 SHALL provide port: B_Data  input  32  requester B write data.
REQ-010 SHALL provide port: B_ack  output  1  one-cycle pulse, B request accepted.
REQ-011 SHALL provide port: D_En  output  1  register-file write enable (registered).
REQ-012 SHALL provide port: D_Addr  output  5  register-file write address (registered).
REQ-013 SHALL provide port: D_in  output  32  register-file write data (registered).
REQ-014 SHALL provide port: B_starve  output  1  high while the arbiter is in FORCE_B state.

Function
REQ-015 A requester SHALL hold req, Addr and Data stable from assertion until the cycle its ack is high, and SHALL drop req or present a new request in the cycle after ack.
REQ-016 The arbiter SHALL grant at most one requester per cycle; ack SHALL be combinational from current req, state and counter, and high only in the grant cycle.
REQ-017 The granted request SHALL appear on D_En/D_Addr/D_in on the clock edge ending the grant cycle (1-cycle latency); without a grant, D_En SHALL be 0 in the following cycle, and D_Addr/D_in SHALL hold their last values.
REQ-018 A grant whose Addr is 5'd0 SHALL still be acked, but the resulting D_En SHALL be 0 (writes to $zero are discarded).
REQ-019 State machine SHALL have two states: PRIO_A (reset state) and FORCE_B.
REQ-020 In PRIO_A: A_req=1 -> grant A; else B_req=1 -> grant B; else no grant.
REQ-021 A 2-bit saturating wait counter SHALL increment on each cycle B_req=1 and B is not granted, and SHALL clear when B is granted or B_req=0.
REQ-022 PRIO_A SHALL go to FORCE_B at the edge where the counter reaches 3 (three consecutive denied B cycles); B_starve SHALL be high only in FORCE_B.
REQ-023 In FORCE_B, B SHALL be granted regardless of A_req; the next state SHALL be PRIO_A and the counter SHALL clear.
REQ-024 When A and B target the same address, writes SHALL reach the register file in grant order; the later grant determines the final value.
REQ-025 A_Data/B_Data SHALL pass unmodified to D_in (full 32 bits, no sign or width change).

Reset
REQ-026 When reset is asserted, the block SHALL immediately set D_En=0, D_Addr=0, D_in=0, state=PRIO_A and counter=0; A_ack, B_ack and B_starve SHALL be 0 while reset is high.
REQ-027 A request that is pending when reset asserts SHALL NOT be acked or written; the requester SHALL keep req high and be arbitrated normally after reset deasserts.

Verification
REQ-028 Scenario: A_req only, A_Addr=5, A_Data=0x12345678 -> A_ack in cycle 0; D_En=1, D_Addr=5, D_in=0x12345678 in cycle 1, and D_En=0 in cycle 2.
REQ-029 Scenario: A_req and B_req held high continuously (A_Addr=1, B_Addr=2) -> A acked cycles 0-2, B_starve=1 and B_ack in cycle 3, A acked cycle 4; the pattern repeats every 4 cycles.
REQ-030 Scenario: B_req only, B_Addr=0, B_Data=0xFFFFFFFF -> B_ack=1 and no D_En pulse in the next cycle.
REQ-031 Scenario: same cycle A_Addr=B_Addr=7, A_Data=0x1, B_Data=0x2 -> writes in order 0x1 then 0x2; $7 final value is 0x2.
REQ-032 Scenario: reset asserted mid-cycle while B_req is pending and the counter is 2 -> outputs zero asynchronously, no ack; after release, B is granted in the first cycle with A_req=0.
REQ-033 Scenario: B_req with the counter at 2, then B_req drops for one cycle -> the counter clears and FORCE_B is not entered.
